dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Memory-access bus between core and data memory.
// Request and response channels, each valid/ready.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_type,
    output req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_type,
    input  req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time,
// programmable wait states, RISC-V B/H/W access.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int BYTE_W = $clog2(4 * DEPTH);
  localparam int IDX_W  = BYTE_W - 2;

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [3:0] WAIT_INIT =
    4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [31:0]       word;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              sx;
  logic              mis;
  logic              oor;
  logic              ill;
  logic              err_c;
  logic [31:0]       ld;
  logic [3:0]        wmask;
  logic [31:0]       wdat;
  logic              do_wr;

  assign idx  = addr_q[BYTE_W-1:2];
  assign word = mem[idx];
  assign bsel = word[8*addr_q[1:0] +: 8];
  assign hsel = addr_q[1] ? word[31:16]
                          : word[15:0];

  assign is_b = (type_q[1:0] == 2'b00);
  assign is_h = (type_q[1:0] == 2'b01);
  assign is_w = (type_q == 3'b010);
  assign sx   = ~type_q[2];

  assign mis = (is_h && addr_q[0]) ||
               (is_w && (addr_q[1:0] != 2'b00));
  assign oor = ({1'b0, addr_q} >= LIMIT);
  assign ill = (type_q == 3'b011) ||
               (type_q[2:1] == 2'b11) ||
               (we_q && type_q[2]);
  assign err_c = mis || oor || ill;

  assign do_wr = (state == EXEC) && we_q && !err_c;

  // Load extraction with sign/zero extension
  always_comb begin
    ld = '0;
    unique case (1'b1)
      is_b:    ld = {{24{sx & bsel[7]}}, bsel};
      is_h:    ld = {{16{sx & hsel[15]}}, hsel};
      is_w:    ld = word;
      default: ld = '0;
    endcase
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    wmask = '0;
    wdat  = '0;
    unique case (1'b1)
      is_b: begin
        wmask = 4'b0001 << addr_q[1:0];
        wdat  = {4{wdata_q[7:0]}};
      end
      is_h: begin
        wmask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{wdata_q[15:0]}};
      end
      is_w: begin
        wmask = 4'b1111;
        wdat  = wdata_q;
      end
      default: begin
        wmask = '0;
        wdat  = '0;
      end
    endcase
  end

  // Storage write, committed at the EXEC edge
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem[idx][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
  end

  // Request/response sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            type_q  <= bus.req_type;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES > 0) begin
              cnt   <= WAIT_INIT;
              state <= WAIT;
            end else begin
              state <= EXEC;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          err_q   <= err_c;
          rdata_q <= (err_c || we_q) ? '0 : ld;
          state   <= RESP;
        end
        default: begin
          if (bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: zero-wait and
// three-wait instances against a byte-level model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(32)) bus0 ();
  dmem_responder_if #(.ADDR_W(32)) bus3 ();

  dmem_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)
  ) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  dmem_responder #(
    .DEPTH(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)
  ) u_w3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic        v_valid  [2];
  logic        v_we     [2];
  logic [2:0]  v_type   [2];
  logic [31:0] v_addr   [2];
  logic [31:0] v_wdata  [2];
  logic        v_rready [2];

  logic        o_ready  [2];
  logic        o_rvalid [2];
  logic [31:0] o_rdata  [2];
  logic        o_err    [2];

  assign bus0.req_valid = v_valid[0];
  assign bus0.req_we    = v_we[0];
  assign bus0.req_type  = v_type[0];
  assign bus0.req_addr  = v_addr[0];
  assign bus0.req_wdata = v_wdata[0];
  assign bus0.rsp_ready = v_rready[0];
  assign bus3.req_valid = v_valid[1];
  assign bus3.req_we    = v_we[1];
  assign bus3.req_type  = v_type[1];
  assign bus3.req_addr  = v_addr[1];
  assign bus3.req_wdata = v_wdata[1];
  assign bus3.rsp_ready = v_rready[1];

  assign o_ready[0]  = bus0.req_ready;
  assign o_rvalid[0] = bus0.rsp_valid;
  assign o_rdata[0]  = bus0.rsp_rdata;
  assign o_err[0]    = bus0.rsp_err;
  assign o_ready[1]  = bus3.req_ready;
  assign o_rvalid[1] = bus3.rsp_valid;
  assign o_rdata[1]  = bus3.rsp_rdata;
  assign o_err[1]    = bus3.rsp_err;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic [7:0]  mref   [2][4*DEPTH];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  bit          pend   [2];
  bit          busy   [2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  function automatic int wc(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  // Reference: access as a sequence of bytes
  task automatic model(input int u,
                       input logic we,
                       input logic [2:0] t,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd,
                       output logic er);
    int n;
    logic [31:0] v;
    logic legal;
    n = (t[1:0] == 2'd0) ? 1 :
        (t[1:0] == 2'd1) ? 2 : 4;
    legal = (t == 3'd0 || t == 3'd1 || t == 3'd2 ||
             t == 3'd4 || t == 3'd5) &&
            !(we && t[2]);
    er = !legal || (a % n != 0) ||
         (a >= 32'(4 * DEPTH));
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++)
          mref[u][a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mref[u][a + i]) << (8 * i));
        if (!t[2] && n == 1 && v[7])
          v = v | 32'hFFFF_FF00;
        if (!t[2] && n == 2 && v[15])
          v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic xfer(input int u,
                      input logic we,
                      input logic [2:0] t,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input int stall,
                      input logic [31:0] lit_rd,
                      input logic lit_er);
    int k;
    int lat;
    logic [31:0] m_rd;
    logic m_er;
    v_we[u]    = we;
    v_type[u]  = t;
    v_addr[u]  = a;
    v_wdata[u] = wd;
    v_valid[u] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!o_ready[u] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!o_ready[u]) begin
      chk("accept_timeout", 32'(o_ready[u]), 32'd1);
      v_valid[u] = 1'b0;
      return;
    end
    @(posedge clk);
    model(u, we, t, a, wd, m_rd, m_er);
    exp_rd[u] = m_rd;
    exp_er[u] = m_er;
    pend[u]   = 1'b1;
    busy[u]   = 1'b1;
    chk($sformatf("pin_rdata@%h", a), m_rd, lit_rd);
    chk($sformatf("pin_err@%h", a),
        32'(m_er), 32'(lit_er));
    #1;
    v_valid[u] = 1'b0;
    v_we[u]    = ~we;
    v_addr[u]  = ~a;
    v_wdata[u] = ~wd;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!o_rvalid[u] && lat < 40);
    chk($sformatf("latency%0d", u),
        32'(lat), 32'(1 + wc(u)));
    if (!o_rvalid[u]) begin
      pend[u] = 1'b0;
      busy[u] = 1'b0;
      return;
    end
    repeat (stall) @(negedge clk);
    v_rready[u] = 1'b1;
    @(posedge clk);
    pend[u] = 1'b0;
    busy[u] = 1'b0;
    #1;
    v_rready[u] = 1'b0;
  endtask

  // Per-cycle output check against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("req_ready%0d", u),
            32'(o_ready[u]), 32'(!busy[u]));
        if (!pend[u])
          chk($sformatf("rsp_valid_idle%0d", u),
              32'(o_rvalid[u]), 32'd0);
        if (o_rvalid[u] && pend[u]) begin
          chk($sformatf("rsp_rdata%0d", u),
              o_rdata[u], exp_rd[u]);
          chk($sformatf("rsp_err%0d", u),
              32'(o_err[u]), 32'(exp_er[u]));
        end else if (!o_rvalid[u]) begin
          chk($sformatf("rsp_zero%0d", u),
              o_rdata[u] | 32'(o_err[u]), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      v_valid[u]  = 1'b0;
      v_we[u]     = 1'b0;
      v_type[u]   = 3'd0;
      v_addr[u]   = '0;
      v_wdata[u]  = '0;
      v_rready[u] = 1'b0;
      pend[u]     = 1'b0;
      busy[u]     = 1'b0;
      exp_rd[u]   = '0;
      exp_er[u]   = 1'b0;
      for (int i = 0; i < 4 * DEPTH; i++)
        mref[u][i] = 8'h00;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_req_ready", 32'(o_ready[u]), 32'd1);
      chk("rst_rsp_valid", 32'(o_rvalid[u]), 32'd0);
      chk("rst_rsp_rdata", o_rdata[u], 32'd0);
      chk("rst_rsp_err", 32'(o_err[u]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // zero wait states
    xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0,
         32'h0, 0);
    xfer(0, 0, 3'b010, 32'h10, 32'h0, 0,
         32'hDEADBEEF, 0);
    xfer(0, 1, 3'b000, 32'h11, 32'h000000AA, 1,
         32'h0, 0);
    xfer(0, 0, 3'b010, 32'h10, 32'h0, 0,
         32'hDEADAAEF, 0);
    xfer(0, 0, 3'b000, 32'h11, 32'h0, 0,
         32'hFFFFFFAA, 0);
    xfer(0, 0, 3'b100, 32'h11, 32'h0, 0,
         32'h000000AA, 0);
    xfer(0, 0, 3'b001, 32'h12, 32'h0, 2,
         32'hFFFFDEAD, 0);
    xfer(0, 0, 3'b101, 32'h12, 32'h0, 0,
         32'h0000DEAD, 0);
    // faults
    xfer(0, 0, 3'b010, 32'h12, 32'h0, 0,
         32'h0, 1);
    xfer(0, 1, 3'b001, 32'h13, 32'h1234, 0,
         32'h0, 1);
    xfer(0, 0, 3'b010, 32'h10, 32'h0, 0,
         32'hDEADAAEF, 0);
    xfer(0, 0, 3'b010, 32'(4 * DEPTH), 32'h0, 0,
         32'h0, 1);
    xfer(0, 0, 3'b010, 32'hFFFFFFFC, 32'h0, 0,
         32'h0, 1);
    xfer(0, 0, 3'b011, 32'h10, 32'h0, 0,
         32'h0, 1);
    xfer(0, 1, 3'b100, 32'h10, 32'h77, 0,
         32'h0, 1);
    xfer(0, 0, 3'b010, 32'h10, 32'h0, 0,
         32'hDEADAAEF, 0);
    // halfword store into upper lanes
    xfer(0, 1, 3'b010, 32'h14, 32'h11223344, 0,
         32'h0, 0);
    xfer(0, 1, 3'b001, 32'h16, 32'hBEEF5678, 0,
         32'h0, 0);
    xfer(0, 0, 3'b010, 32'h14, 32'h0, 0,
         32'h56783344, 0);
    xfer(0, 0, 3'b001, 32'h16, 32'h0, 0,
         32'h00005678, 0);

    // three wait states, stalled response
    xfer(1, 1, 3'b010, 32'h20, 32'h0, 0,
         32'h0, 0);
    xfer(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0,
         32'h0, 0);
    xfer(1, 0, 3'b010, 32'h40, 32'h0, 5,
         32'hCAFEF00D, 0);

    // reset during WAIT of a store
    v_we[1]    = 1'b1;
    v_type[1]  = 3'b010;
    v_addr[1]  = 32'h20;
    v_wdata[1] = 32'h55;
    v_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_test_ready", 32'(o_ready[1]), 32'd1);
    @(posedge clk);
    busy[1] = 1'b1;
    #1 v_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_ready_low", 32'(o_ready[1]), 32'd0);
    rst_n   = 1'b0;
    busy[1] = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_ready[1]), 32'd1);
    chk("mid_rst_valid", 32'(o_rvalid[1]), 32'd0);
    chk("mid_rst_rdata", o_rdata[1], 32'd0);
    chk("mid_rst_err", 32'(o_err[1]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(o_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    xfer(1, 0, 3'b010, 32'h20, 32'h0, 0,
         32'h0, 0);
    xfer(0, 0, 3'b010, 32'h10, 32'h0, 0,
         32'hDEADAAEF, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end

endmodule
